// File: rtl/bg_rom_pkg.sv
// Shared definitions for the background ROM read scheduler: port identifiers
// and the tag that follows each ROM read through the read latency.
package bg_rom_pkg;

    localparam logic PORT_DISP = 1'b0;
    localparam logic PORT_OVL  = 1'b1;

    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

endpackage

// File: rtl/bg_rom_rd_sched_if.sv
// Request/response bus for the two ROM read ports; the scheduler is the slave,
// the display and overlay fetchers together form the master side.
interface bg_rom_rd_sched_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic                  req0_ready;
    logic                  rsp0_valid;
    logic [DATA_WIDTH-1:0] rsp0_data;

    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic                  req1_ready;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp1_data;

    modport master (
        output req0_valid, req0_addr, req1_valid, req1_addr,
        input  req0_ready, rsp0_valid, rsp0_data,
        input  req1_ready, rsp1_valid, rsp1_data
    );

    modport slave (
        input  req0_valid, req0_addr, req1_valid, req1_addr,
        output req0_ready, rsp0_valid, rsp0_data,
        output req1_ready, rsp1_valid, rsp1_data
    );
endinterface

// File: rtl/bg_rom_tag_pipe.sv
// DEPTH-stage shift register of read tags, advancing only while the ROM is
// clocked so tag position always matches the ROM's internal data position.
module bg_rom_tag_pipe
    import bg_rom_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  tag_t i_tag,
    output tag_t o_last,
    output logic o_any_vld
);
    tag_t r_stage [DEPTH];

    // NOTE: only DEPTH (1..2) small flops, so every stage is reset; this is
    // what kills reads that are in flight when reset arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else if (i_en) begin
            // NOTE: non-blocking assignments let every stage shift in parallel
            // regardless of statement order.
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    always_comb begin
        o_any_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) o_any_vld = o_any_vld | r_stage[i].vld;
    end

    assign o_last = r_stage[DEPTH-1];

endmodule

// File: rtl/bg_rom_rd_sched.sv
// Two-port read scheduler for the single-port background ROM: fixed priority
// to port 0 with a starvation override for port 1, tagged in-order responses.
module bg_rom_rd_sched
    import bg_rom_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAX_STALL  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    bg_rom_rd_sched_if.slave      bus,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_clk_en,
    output logic                  rom_rd_oce,
    input  logic [DATA_WIDTH-1:0] rom_rd_data,
    output logic [7:0]            stall_cnt
);
    logic                  w_force1;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_gnt_any;
    logic                  w_any_vld;
    tag_t                  w_tag_in;
    tag_t                  w_tag_last;
    logic [7:0]            r_stall;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_rsp0_valid;
    logic                  r_rsp1_valid;
    logic [DATA_WIDTH-1:0] r_rsp0_data;
    logic [DATA_WIDTH-1:0] r_rsp1_data;

    // NOTE: both grants get a default before any condition, so this block can
    // never infer a latch.
    always_comb begin
        w_force1 = (r_stall == 8'(MAX_STALL));
        w_gnt0   = 1'b0;
        w_gnt1   = 1'b0;
        if (rst_n && en) begin
            if (bus.req1_valid && (w_force1 || !bus.req0_valid)) w_gnt1 = 1'b1;
            else if (bus.req0_valid)                               w_gnt0 = 1'b1;
        end
    end

    assign w_gnt_any    = w_gnt0 | w_gnt1;
    assign w_tag_in.vld = w_gnt_any;
    assign w_tag_in.id  = w_gnt1 ? PORT_OVL : PORT_DISP;

    // The ROM samples the address at the accept edge; hold it otherwise.
    assign rom_addr = w_gnt1 ? bus.req1_addr : (w_gnt0 ? bus.req0_addr : r_addr);

    always_ff @(posedge clk) begin
        if (!rst_n)         r_addr <= '0;
        else if (w_gnt_any) r_addr <= rom_addr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (en) begin
            if (!bus.req1_valid || w_gnt1)           r_stall <= '0;
            else if (w_gnt0 && !w_force1)            r_stall <= r_stall + 8'd1;
        end
    end

    bg_rom_tag_pipe #(.DEPTH(RD_LATENCY)) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (rom_clk_en),
        .i_tag     (w_tag_in),
        .o_last    (w_tag_last),
        .o_any_vld (w_any_vld)
    );

    // ROM is clocked only while a read is being issued or is still in flight.
    assign rom_clk_en = rst_n & (w_gnt_any | w_any_vld);
    assign rom_rd_oce = rom_clk_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_data  <= '0;
            r_rsp1_data  <= '0;
        end else begin
            r_rsp0_valid <= w_tag_last.vld && (w_tag_last.id == PORT_DISP);
            r_rsp1_valid <= w_tag_last.vld && (w_tag_last.id == PORT_OVL);
            if (w_tag_last.vld && (w_tag_last.id == PORT_DISP)) r_rsp0_data <= rom_rd_data;
            if (w_tag_last.vld && (w_tag_last.id == PORT_OVL))  r_rsp1_data <= rom_rd_data;
        end
    end

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp0_data  = r_rsp0_data;
    assign bus.rsp1_data  = r_rsp1_data;
    assign stall_cnt      = r_stall;

endmodule

// File: tb/tb_bg_rom_rd_sched.sv
// Scoreboard bench for bg_rom_rd_sched: one instance with RD_LATENCY=1 and one
// with RD_LATENCY=2 receive identical directed stimulus, each with a ROM model.
module tb_bg_rom_rd_sched;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MS = 8;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          v0;
    logic          v1;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;

    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    exp_t          sb_q [4][$];
    int            rsp_seen [4];
    int            gnt0_cnt [2];

    logic          r0_o [2];
    logic          r1_o [2];
    logic          ce_o [2];
    logic [AW-1:0] ra_o [2];
    logic [7:0]    st_o [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return {16'hB9A0 ^ 16'(a), 6'd0, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mon(input int qi, input logic [DW-1:0] d, input int lat);
        exp_t e;
        rsp_seen[qi]++;
        if (sb_q[qi].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp q%0d c%0d: got data 0x%0h, expected no response", qi, cyc, d);
        end else begin
            e = sb_q[qi].pop_front();
            check($sformatf("rsp_data q%0d c%0d", qi, cyc), d, e.data);
            check($sformatf("rsp_cycle q%0d", qi), cyc, e.cyc + lat + 1);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam int L = k + 1;
        bg_rom_rd_sched_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
        logic [AW-1:0] rom_addr;
        logic          rom_clk_en;
        logic          rom_rd_oce;
        logic [DW-1:0] rom_rd_data;
        logic [DW-1:0] rom_q1;
        logic [DW-1:0] rom_q2;
        logic [7:0]    stall_cnt;

        assign bus.req0_valid = v0;
        assign bus.req0_addr  = a0;
        assign bus.req1_valid = v1;
        assign bus.req1_addr  = a1;

        bg_rom_rd_sched #(
            .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L), .MAX_STALL(MS)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .en          (en),
            .bus         (bus),
            .rom_addr    (rom_addr),
            .rom_clk_en  (rom_clk_en),
            .rom_rd_oce  (rom_rd_oce),
            .rom_rd_data (rom_rd_data),
            .stall_cnt   (stall_cnt)
        );

        // ROM model: address register, optional output register.
        always @(posedge clk) if (rom_clk_en) rom_q1 <= rom_word(rom_addr);
        always @(posedge clk) if (rom_clk_en && rom_rd_oce) rom_q2 <= rom_q1;
        assign rom_rd_data = (L == 2) ? rom_q2 : rom_q1;

        assign r0_o[k] = bus.req0_ready;
        assign r1_o[k] = bus.req1_ready;
        assign ce_o[k] = rom_clk_en;
        assign ra_o[k] = rom_addr;
        assign st_o[k] = stall_cnt;

        always @(negedge clk) begin
            if (bus.rsp0_valid === 1'b1) mon(k*2,   bus.rsp0_data, L);
            if (bus.rsp1_valid === 1'b1) mon(k*2+1, bus.rsp1_data, L);
        end
    end

    // One cycle of stimulus; checks at the falling edge, expected responses
    // are queued from the hand-computed grant, not from the DUT.
    task automatic drive(input logic iv0, input int ia0, input logic iv1, input int ia1,
                         input logic ien, input logic er0, input logic er1, input int es,
                         input int ea, input int ece, input bit push);
        exp_t e;
        v0 = iv0; a0 = AW'(ia0); v1 = iv1; a1 = AW'(ia1); en = ien;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("req0_ready i%0d c%0d", k, cyc), r0_o[k], er0);
            check($sformatf("req1_ready i%0d c%0d", k, cyc), r1_o[k], er1);
            check($sformatf("stall_cnt i%0d c%0d", k, cyc), st_o[k], es);
            if (ea >= 0)  check($sformatf("rom_addr i%0d c%0d", k, cyc), ra_o[k], ea);
            if (ece >= 0) check($sformatf("rom_clk_en i%0d c%0d", k, cyc), ce_o[k], ece);
            if (r0_o[k] === 1'b1) gnt0_cnt[k]++;
            e.cyc = cyc;
            if (push && er0) begin e.data = rom_word(AW'(ia0)); sb_q[k*2].push_back(e);   end
            if (push && er1) begin e.data = rom_word(AW'(ia1)); sb_q[k*2+1].push_back(e); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int es, input int ea, input int ece);
        drive(0, 0, 0, 0, 1, 0, 0, es, ea, ece, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen5 [4];
        rst_n = 0; en = 1; v0 = 1; v1 = 1; a0 = '0; a1 = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset held with both requests pending.
        repeat (3) drive(1, 'h11, 1, 'h22, 1, 0, 0, 0, 0, 0, 0);
        rst_n = 1;
        idle(0, 0, 0);

        // Single port-1 read.
        drive(0, 0, 1, 'h05, 1, 0, 1, 0, 'h05, 1, 1);
        repeat (4) idle(0, 'h05, -1);

        // Contention: forced port-1 grant on cycles 9 and 18.
        gnt0_cnt[0] = 0; gnt0_cnt[1] = 0;
        for (int c = 1; c <= 20; c++)
            drive(1, 'h100 + c, 1, 'h200 + c, 1, (c % 9) != 0, (c % 9) == 0, (c - 1) % 9,
                  ((c % 9) == 0) ? 'h200 + c : 'h100 + c, 1, 1);
        for (int k = 0; k < 2; k++) check($sformatf("port0_grants i%0d", k), gnt0_cnt[k], 18);
        idle(2, 'h114, -1);
        repeat (4) idle(0, 'h114, -1);

        // Streaming port 0.
        for (int i = 0; i < 16; i++) drive(1, i, 0, 0, 1, 1, 0, 0, i, 1, 1);
        repeat (4) idle(0, 15, -1);

        // Reset one cycle after accepting a read: no response may follow.
        drive(1, 'h3FF, 0, 0, 1, 1, 0, 0, 'h3FF, 1, 0);
        for (int q = 0; q < 4; q++) seen5[q] = rsp_seen[q];
        rst_n = 0;
        idle(0, -1, -1);
        idle(0, 0, 0);
        rst_n = 1;
        repeat (5) idle(0, 0, 0);
        for (int k = 0; k < 2; k++)
            check($sformatf("rsp0_after_reset i%0d", k), rsp_seen[k*2] - seen5[k*2], 0);

        // en low with a read in flight: response delivered, no new grants.
        drive(1, 'h20, 1, 'h30, 1, 1, 0, 0, 'h20, 1, 1);
        for (int j = 0; j < 5; j++)
            drive(1, 'h21, 1, 'h31, 0, 0, 0, 1, 'h20, (j == 0) ? 1 : ((j >= 2) ? 0 : -1), 0);
        idle(1, 'h20, -1);
        repeat (4) idle(0, 'h20, 0);

        for (int q = 0; q < 4; q++) check($sformatf("sb_empty q%0d", q), sb_q[q].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
